// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, microword bit positions and opcodes.
// The control unit and the accumulator datapath both decode against these.
package cpu_pkg;

  localparam int DATA_W = 16;

  // Microword bit positions
  localparam int CS_PC2MAR         = 0;
  localparam int CS_PC_INC         = 1;
  localparam int CS_MAR2MEM        = 2;
  localparam int CS_MEM2MBR        = 3;
  localparam int CS_MBR2MEM        = 4;
  localparam int CS_MBR2IR         = 5;
  localparam int CS_MBR2BR         = 6;
  localparam int CS_IR2PC          = 7;
  localparam int CS_IR2MAR         = 8;
  localparam int CS_MBR2PC         = 9;
  localparam int CS_MBR2ACC        = 10;
  localparam int CS_ACC2MBR        = 11;
  localparam int CS_PC2MBR         = 12;
  localparam int CS_SP_INC         = 13;
  localparam int CS_SP_DEC         = 14;
  localparam int CS_SP2MAR         = 15;
  localparam int CS_MPY_ALU2MR     = 16;
  localparam int CS_MR2ACC         = 17;
  localparam int CS_MEM_READ       = 18;
  localparam int CS_MEM_WRITE      = 19;
  localparam int CS_HALT           = 20;
  localparam int CS_ACC_CLEAR      = 21;
  localparam int CS_ADDITION       = 22;
  localparam int CS_SUBTRACTION    = 23;
  localparam int CS_AND_OP         = 24;
  localparam int CS_OR_OP          = 25;
  localparam int CS_NOT_OP         = 26;
  localparam int CS_LSL            = 27;
  localparam int CS_LSR            = 28;
  localparam int CS_MPY_OPERATION  = 29;
  localparam int CS_ASL            = 30;
  localparam int CS_ASR            = 31;

  // Instruction opcodes
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_AND   = 8'h05;
  localparam logic [7:0] OP_OR    = 8'h06;
  localparam logic [7:0] OP_NOT   = 8'h07;
  localparam logic [7:0] OP_SHL   = 8'h08;
  localparam logic [7:0] OP_SHR   = 8'h09;
  localparam logic [7:0] OP_MPY   = 8'h0A;
  localparam logic [7:0] OP_JMP   = 8'h0B;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT,
    ALU_LSL, ALU_LSR, ALU_MPY, ALU_ASL, ALU_ASR
  } alu_op_e;

endpackage

// File: rtl/mul_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// done and product are valid in the final busy cycle, so the caller loads on the edge busy falls.
module mul_seq #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   mcand;
  logic [2*DATA_W-1:0] part;
  logic [DATA_W:0]     upper;
  logic [2*DATA_W-1:0] step;

  always_comb begin
    upper = {1'b0, part[2*DATA_W-1:DATA_W]} + (part[0] ? {1'b0, mcand} : '0);
    step  = {upper, part[DATA_W-1:1]};
  end

  assign done    = busy && (cnt == CNT_W'(1));
  assign product = step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      mcand <= '0;
      part  <= '0;
      busy  <= 1'b0;
    end else if (start && !busy) begin
      cnt   <= CNT_W'(DATA_W);
      mcand <= a;
      part  <= {{DATA_W{1'b0}}, b};
      busy  <= 1'b1;
    end else if (busy) begin
      part <= step;
      cnt  <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1))
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_acc.sv
// Accumulator datapath: ACC/BR/MR registers, ALU and status flags, driven by
// microword edges (a word acts only in the cycle it differs from the previous one).
import cpu_pkg::*;

module alu_acc #(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       control_signal,
  input  logic [DATA_W-1:0] mbr_data,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] br,
  output logic [DATA_W-1:0] mr,
  output logic [7:0]        flags,
  output logic              busy
);

  logic [31:0]         prev_cs;
  logic [DATA_W-1:0]   acc_q, br_q, mr_q, phi_q;
  logic                flag_n, flag_z, flag_c, flag_v;
  logic                mr_pending;
  logic                new_word, act, mr_req;
  alu_op_e             op;
  logic [DATA_W-1:0]   a_op, alu_res, acc_nxt;
  logic                alu_c, alu_v, alu_we, acc_we, mpy_start;
  logic [DATA_W:0]     add_t, sub_t, shl_t, shr_t, asr_t;
  logic [3:0]          shamt;
  logic                mul_busy, mul_done;
  logic [2*DATA_W-1:0] product;

  assign new_word = (control_signal != prev_cs);
  assign act      = new_word && !mul_busy;
  assign mr_req   = new_word && control_signal[CS_MPY_ALU2MR];

  // Lowest set ALU bit wins
  always_comb begin
    op = ALU_NONE;
    if (act) begin
      if      (control_signal[CS_ADDITION])      op = ALU_ADD;
      else if (control_signal[CS_SUBTRACTION])   op = ALU_SUB;
      else if (control_signal[CS_AND_OP])        op = ALU_AND;
      else if (control_signal[CS_OR_OP])         op = ALU_OR;
      else if (control_signal[CS_NOT_OP])        op = ALU_NOT;
      else if (control_signal[CS_LSL])           op = ALU_LSL;
      else if (control_signal[CS_LSR])           op = ALU_LSR;
      else if (control_signal[CS_MPY_OPERATION]) op = ALU_MPY;
      else if (control_signal[CS_ASL])           op = ALU_ASL;
      else if (control_signal[CS_ASR])           op = ALU_ASR;
    end
  end

  // Shift temporaries carry one extra bit so the last bit shifted out falls into it.
  always_comb begin
    a_op    = (act && control_signal[CS_ACC_CLEAR]) ? '0 : acc_q;
    shamt   = br_q[3:0];
    add_t   = {1'b0, a_op} + {1'b0, br_q};
    sub_t   = {1'b0, a_op} - {1'b0, br_q};
    shl_t   = {1'b0, a_op} << shamt;
    shr_t   = {a_op, 1'b0} >> shamt;
    asr_t   = $signed({a_op, 1'b0}) >>> shamt;
    alu_res = a_op;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      ALU_ADD: begin
        alu_res = add_t[DATA_W-1:0];
        alu_c   = add_t[DATA_W];
        alu_v   = (a_op[DATA_W-1] == br_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_op[DATA_W-1]);
      end
      ALU_SUB: begin
        alu_res = sub_t[DATA_W-1:0];
        alu_c   = ~sub_t[DATA_W];
        alu_v   = (a_op[DATA_W-1] != br_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_op[DATA_W-1]);
      end
      ALU_AND: alu_res = a_op & br_q;
      ALU_OR:  alu_res = a_op | br_q;
      ALU_NOT: alu_res = ~br_q;
      ALU_LSL: begin
        alu_res = shl_t[DATA_W-1:0];
        alu_c   = shl_t[DATA_W];
      end
      ALU_LSR: begin
        alu_res = shr_t[DATA_W:1];
        alu_c   = shr_t[0];
      end
      ALU_ASL: begin
        alu_res = shl_t[DATA_W-1:0];
        alu_c   = shl_t[DATA_W];
        alu_v   = ($signed(alu_res) >>> shamt) != $signed(a_op);
      end
      ALU_ASR: begin
        alu_res = asr_t[DATA_W:1];
        alu_c   = asr_t[0];
      end
      default: ;
    endcase
  end

  assign alu_we    = (op != ALU_NONE) && (op != ALU_MPY);
  assign mpy_start = (op == ALU_MPY);

  always_comb begin
    acc_nxt = acc_q;
    acc_we  = 1'b0;
    if (mul_done) begin
      acc_nxt = product[DATA_W-1:0];
      acc_we  = 1'b1;
    end else if (alu_we) begin
      acc_nxt = alu_res;
      acc_we  = 1'b1;
    end else if (act && control_signal[CS_MBR2ACC]) begin
      acc_nxt = mbr_data;
      acc_we  = 1'b1;
    end else if (act && control_signal[CS_ACC_CLEAR]) begin
      acc_nxt = '0;
      acc_we  = 1'b1;
    end
  end

  mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mpy_start),
    .a       (a_op),
    .b       (br_q),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_cs    <= '0;
      acc_q      <= '0;
      br_q       <= '0;
      mr_q       <= '0;
      phi_q      <= '0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      mr_pending <= 1'b0;
    end else begin
      prev_cs <= control_signal;
      if (new_word && control_signal[CS_MBR2BR])
        br_q <= mbr_data;
      if (acc_we) begin
        acc_q  <= acc_nxt;
        flag_n <= acc_nxt[DATA_W-1];
        flag_z <= (acc_nxt == '0);
      end
      if (alu_we) begin
        flag_c <= alu_c;
        flag_v <= alu_v;
      end
      if (mul_done) begin
        phi_q  <= product[2*DATA_W-1:DATA_W];
        flag_c <= 1'b0;
        flag_v <= 1'b0;
      end
      // A transfer requested mid-multiply is deferred to the completion edge
      if (mul_done && (mr_pending || mr_req)) begin
        mr_q       <= product[2*DATA_W-1:DATA_W];
        mr_pending <= 1'b0;
      end else if (mr_req) begin
        if (mul_busy) mr_pending <= 1'b1;
        else          mr_q       <= phi_q;
      end
    end
  end

  assign acc   = acc_q;
  assign br    = br_q;
  assign mr    = mr_q;
  assign flags = {4'b0000, flag_v, flag_c, flag_z, flag_n};
  assign busy  = mul_busy;

endmodule

// File: tb/tb_alu_acc.sv
// Directed bench for alu_acc: expected register state is queued per microword
// and a negedge monitor compares it against the DUT at the tagged cycle.
import cpu_pkg::*;

module tb_alu_acc;

  logic        clk;
  logic        rst;
  logic [31:0] control_signal;
  logic [15:0] mbr_data;
  logic [15:0] acc, br, mr;
  logic [7:0]  flags;
  logic        busy;

  typedef struct {
    int          tag;
    string       nm;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] m;
    logic [7:0]  f;
    logic        bz;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0;

  alu_acc #(.DATA_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .control_signal (control_signal),
    .mbr_data       (mbr_data),
    .acc            (acc),
    .br             (br),
    .mr             (mr),
    .flags          (flags),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag <= cyc) begin
      mon_e = q.pop_front();
      checks++;
      if (mon_e.tag < cyc) begin
        errors++;
        $display("FAIL %s: check missed, tag %0d now cycle %0d", mon_e.nm, mon_e.tag, cyc);
      end else if ({acc, br, mr, flags, busy} !== {mon_e.a, mon_e.b, mon_e.m, mon_e.f, mon_e.bz}) begin
        errors++;
        $display("FAIL %s: got acc=%h br=%h mr=%h flags=%h busy=%b, want acc=%h br=%h mr=%h flags=%h busy=%b",
                 mon_e.nm, acc, br, mr, flags, busy, mon_e.a, mon_e.b, mon_e.m, mon_e.f, mon_e.bz);
      end
    end
  end

  function automatic logic [31:0] cb(int i);
    logic [31:0] one;
    one = 32'd1;
    return one << i;
  endfunction

  task automatic expect_at(int tag, string nm, logic [15:0] a, logic [15:0] b,
                           logic [15:0] m, logic [7:0] f, logic bz);
    exp_t e;
    e.tag = tag; e.nm = nm; e.a = a; e.b = b; e.m = m; e.f = f; e.bz = bz;
    q.push_back(e);
  endtask

  // Hold a word for 'hold' edges, then one idle zero word
  task automatic send(string nm, logic [31:0] cs, logic [15:0] mbr, int hold,
                      logic [15:0] a, logic [15:0] b, logic [15:0] m, logic [7:0] f, logic bz);
    expect_at(cyc + hold, nm, a, b, m, f, bz);
    control_signal = cs;
    mbr_data       = mbr;
    repeat (hold) @(posedge clk);
    #1;
    control_signal = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    control_signal = '0;
    mbr_data       = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    send("reset_state",  32'd0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0);
    send("ld_br5",       cb(CS_MBR2BR), 16'h0005, 1, 16'h0000, 16'h0005, 16'h0000, 8'h00, 1'b0);
    send("clr_add",      cb(CS_ACC_CLEAR) | cb(CS_ADDITION), 16'h0000, 1, 16'h0005, 16'h0005, 16'h0000, 8'h00, 1'b0);
    send("ld_acc_7fff",  cb(CS_MBR2ACC), 16'h7FFF, 1, 16'h7FFF, 16'h0005, 16'h0000, 8'h00, 1'b0);
    send("ld_br1",       cb(CS_MBR2BR), 16'h0001, 1, 16'h7FFF, 16'h0001, 16'h0000, 8'h00, 1'b0);
    send("add_ovf",      cb(CS_ADDITION), 16'h0000, 1, 16'h8000, 16'h0001, 16'h0000, 8'h09, 1'b0);
    send("ld_acc3_keepv", cb(CS_MBR2ACC), 16'h0003, 1, 16'h0003, 16'h0001, 16'h0000, 8'h08, 1'b0);
    send("ld_br4",       cb(CS_MBR2BR), 16'h0004, 1, 16'h0003, 16'h0004, 16'h0000, 8'h08, 1'b0);
    send("sub_neg",      cb(CS_SUBTRACTION), 16'h0000, 1, 16'hFFFF, 16'h0004, 16'h0000, 8'h01, 1'b0);
    send("ld_acc_8001",  cb(CS_MBR2ACC), 16'h8001, 1, 16'h8001, 16'h0004, 16'h0000, 8'h01, 1'b0);
    send("ld_br1b",      cb(CS_MBR2BR), 16'h0001, 1, 16'h8001, 16'h0001, 16'h0000, 8'h01, 1'b0);
    send("asr",          cb(CS_ASR), 16'h0000, 1, 16'hC000, 16'h0001, 16'h0000, 8'h05, 1'b0);
    send("ld_acc_8001b", cb(CS_MBR2ACC), 16'h8001, 1, 16'h8001, 16'h0001, 16'h0000, 8'h05, 1'b0);
    send("lsr",          cb(CS_LSR), 16'h0000, 1, 16'h4000, 16'h0001, 16'h0000, 8'h04, 1'b0);
    send("ld_acc1",      cb(CS_MBR2ACC), 16'h0001, 1, 16'h0001, 16'h0001, 16'h0000, 8'h04, 1'b0);
    send("sub_zero",     cb(CS_SUBTRACTION), 16'h0000, 1, 16'h0000, 16'h0001, 16'h0000, 8'h06, 1'b0);
    send("prio_add_sub", cb(CS_ADDITION) | cb(CS_SUBTRACTION), 16'h0000, 1, 16'h0001, 16'h0001, 16'h0000, 8'h00, 1'b0);
    send("hold_add_once", cb(CS_ADDITION), 16'h0000, 2, 16'h0002, 16'h0001, 16'h0000, 8'h00, 1'b0);
    send("ld_acc_4001",  cb(CS_MBR2ACC), 16'h4001, 1, 16'h4001, 16'h0001, 16'h0000, 8'h00, 1'b0);
    send("ld_br2",       cb(CS_MBR2BR), 16'h0002, 1, 16'h4001, 16'h0002, 16'h0000, 8'h00, 1'b0);
    send("asl_ovf",      cb(CS_ASL), 16'h0000, 1, 16'h0004, 16'h0002, 16'h0000, 8'h0C, 1'b0);
    send("ld_br_10",     cb(CS_MBR2BR), 16'h0010, 1, 16'h0004, 16'h0010, 16'h0000, 8'h0C, 1'b0);
    send("lsl_cnt0",     cb(CS_LSL), 16'h0000, 1, 16'h0004, 16'h0010, 16'h0000, 8'h00, 1'b0);
    send("not",          cb(CS_NOT_OP), 16'h0000, 1, 16'hFFEF, 16'h0010, 16'h0000, 8'h01, 1'b0);
    send("and_zero",     cb(CS_AND_OP), 16'h0000, 1, 16'h0000, 16'h0010, 16'h0000, 8'h02, 1'b0);
    send("or",           cb(CS_OR_OP), 16'h0000, 1, 16'h0010, 16'h0010, 16'h0000, 8'h00, 1'b0);
    send("ld_acc_1234",  cb(CS_MBR2ACC), 16'h1234, 1, 16'h1234, 16'h0010, 16'h0000, 8'h00, 1'b0);
    send("ld_br_100",    cb(CS_MBR2BR), 16'h0100, 1, 16'h1234, 16'h0100, 16'h0000, 8'h00, 1'b0);

    // Multiply: start at edge c0+1, result on edge c0+17
    c0 = cyc;
    send("mpy_start",    cb(CS_MPY_OPERATION), 16'h0000, 1, 16'h1234, 16'h0100, 16'h0000, 8'h00, 1'b1);
    send("mr_pending",   cb(CS_MPY_ALU2MR), 16'h0000, 1, 16'h1234, 16'h0100, 16'h0000, 8'h00, 1'b1);
    send("busy_ignored", cb(CS_MBR2BR) | cb(CS_ACC_CLEAR) | cb(CS_ADDITION), 16'h0200, 1,
         16'h1234, 16'h0200, 16'h0000, 8'h00, 1'b1);
    expect_at(c0 + 16, "busy_last", 16'h1234, 16'h0200, 16'h0000, 8'h00, 1'b1);
    expect_at(c0 + 17, "mpy_done",  16'h3400, 16'h0200, 16'h0012, 8'h00, 1'b0);
    repeat (14) @(posedge clk);
    #1;

    // Reset during the fifth busy cycle of a second multiply
    send("mpy2_start",   cb(CS_MPY_OPERATION), 16'h0000, 1, 16'h3400, 16'h0200, 16'h0012, 8'h00, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    expect_at(cyc, "rst_async", 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    send("mr_after_rst", cb(CS_MPY_ALU2MR), 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    send("no_partial",   32'd0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never compared, tag %0d", mon_e.nm, mon_e.tag);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
